lcd_sequencer: RTL and testbench

LCD_SEQUENCER -- requirements
Module: lcd_sequencer

---
 rtl/lcd_sequencer.sv | 171 +++++++++++++++++
 tb/tb_lcd_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_sequencer.sv
`default_nettype none
// ============================================================================
// lcd_sequencer : HD44780-style LCD write sequencer with power-up init.
// Optional cursor tracking / automatic line wrap: define LCD_WRAP_EN.
// Rev 1.0
// ============================================================================
module lcd_sequencer #(
  parameter logic [19:0] E_HIGH     = 20'h40000,
  parameter logic [19:0] INTER_WAIT = 20'h200,
  parameter logic [19:0] LONG_WAIT  = 20'h40000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       init_done,
  output logic       e,
  output logic       rs,
  output logic [7:0] data_out
);

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    STROBE = 2'd1,
    HOLD   = 2'd2,
    IDLE   = 2'd3
  } state_t;

  state_t      state_q;
  logic [19:0] cnt_q;
  logic [2:0]  idx_q;
  logic        e_q;
  logic        rs_q;
  logic [7:0]  data_q;
  logic        init_done_q;
  logic        long_d;

`ifdef LCD_WRAP_EN
  logic [3:0]  col_q;
  logic        line_q;
  logic        ins_pend_q;
  logic [7:0]  ins_data_q;
`endif

  function automatic logic [7:0] init_cmd(input logic [2:0] i);
    case (i)
      3'd0, 3'd1, 3'd2, 3'd3: init_cmd = 8'h3C;
      3'd4:                   init_cmd = 8'h08;
      3'd5:                   init_cmd = 8'h01;
      3'd6:                   init_cmd = 8'h06;
      default:                init_cmd = 8'h0C;
    endcase
  endfunction

  // Clear and home commands need the long settle time; the byte is still on the bus.
  assign long_d = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      cnt_q       <= 20'd0;
      idx_q       <= 3'd0;
      e_q         <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      init_done_q <= 1'b0;
`ifdef LCD_WRAP_EN
      col_q       <= 4'd0;
      line_q      <= 1'b0;
      ins_pend_q  <= 1'b0;
      ins_data_q  <= 8'h00;
`endif
    end else begin
      case (state_q)
        INIT: begin
          e_q     <= 1'b1;
          rs_q    <= 1'b0;
          data_q  <= init_cmd(idx_q);
          cnt_q   <= E_HIGH;
          state_q <= STROBE;
        end
        STROBE: begin
          if (cnt_q != 20'd0) begin
            cnt_q <= cnt_q - 20'd1;
          end else begin
            e_q     <= 1'b0;
            cnt_q   <= long_d ? LONG_WAIT : INTER_WAIT;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (cnt_q != 20'd0) begin
            cnt_q <= cnt_q - 20'd1;
          end else if (!init_done_q) begin
            if (idx_q == 3'd7) begin
              init_done_q <= 1'b1;
              state_q     <= IDLE;
`ifdef LCD_WRAP_EN
              col_q       <= 4'd0;
              line_q      <= 1'b0;
`endif
            end else begin
              // Chain straight into the next init strobe so the gap is exactly wait+1.
              idx_q   <= idx_q + 3'd1;
              e_q     <= 1'b1;
              rs_q    <= 1'b0;
              data_q  <= init_cmd(idx_q + 3'd1);
              cnt_q   <= E_HIGH;
              state_q <= STROBE;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        IDLE: begin
`ifdef LCD_WRAP_EN
          if (ins_pend_q) begin
            ins_pend_q <= 1'b0;
            e_q        <= 1'b1;
            rs_q       <= 1'b0;
            data_q     <= ins_data_q;
            cnt_q      <= E_HIGH;
            state_q    <= STROBE;
          end else
`endif
          if (req_valid && req_ready) begin
            e_q     <= 1'b1;
            rs_q    <= req_rs;
            data_q  <= req_data;
            cnt_q   <= E_HIGH;
            state_q <= STROBE;
`ifdef LCD_WRAP_EN
            if (req_rs) begin
              if (col_q == 4'hF) begin
                col_q      <= 4'd0;
                line_q     <= ~line_q;
                ins_pend_q <= 1'b1;
                ins_data_q <= line_q ? 8'h80 : 8'hC0;
              end else begin
                col_q <= col_q + 4'd1;
              end
            end else if (req_data[7]) begin
              col_q  <= req_data[3:0];
              line_q <= req_data[6];
            end else if (req_data == 8'h01 || req_data == 8'h02 || req_data == 8'h03) begin
              col_q  <= 4'd0;
              line_q <= 1'b0;
            end
`endif
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

`ifdef LCD_WRAP_EN
  assign req_ready = (state_q == IDLE) && init_done_q && !ins_pend_q;
`else
  assign req_ready = (state_q == IDLE) && init_done_q;
`endif

  assign init_done = init_done_q;
  assign e         = e_q;
  assign rs        = rs_q;
  assign data_out  = data_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_sequencer.sv
`default_nettype none
// Directed bench for lcd_sequencer with E_HIGH=3, INTER_WAIT=2, LONG_WAIT=10.
module tb_lcd_sequencer;

  localparam logic [19:0] EH = 20'd3;
  localparam logic [19:0] IW = 20'd2;
  localparam logic [19:0] LW = 20'd10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       req_ready;
  logic       init_done;
  logic       e;
  logic       rs;
  logic [7:0] data_out;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         gap;
  } vec_t;

  vec_t       tbl[7];
  logic [7:0] init_tbl[8];

  lcd_sequencer #(.E_HIGH(EH), .INTER_WAIT(IW), .LONG_WAIT(LW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_rs(req_rs),
    .req_data(req_data), .req_ready(req_ready), .init_done(init_done),
    .e(e), .rs(rs), .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits for e high, measures its width, then the low gap until e rises or req_ready.
  task automatic check_strobe(input string nm, input logic ers, input logic [7:0] ed, input int egap);
    int n = 0;
    int hi = 0;
    int gap = 0;
    int uns = 0;
    logic srs;
    logic [7:0] sd;
    while (!e && n < 200) begin
      @(negedge clk);
      n++;
    end
    srs = rs;
    sd  = data_out;
    while (e && hi < 100) begin
      if (rs !== srs || data_out !== sd) uns++;
      hi++;
      @(negedge clk);
    end
    while (!e && !req_ready && gap < 100) begin
      gap++;
      @(negedge clk);
    end
    chk({nm, ".data"}, 32'(sd), 32'(ed));
    chk({nm, ".rs"}, 32'(srs), 32'(ers));
    chk({nm, ".e_width"}, hi, 4);
    chk({nm, ".gap"}, gap, egap);
    chk({nm, ".bus_stable"}, uns, 0);
  endtask

  task automatic send(input logic r, input logic [7:0] d, input logic hold_valid);
    int n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_req", 32'(req_ready), 1);
    req_valid = 1'b1;
    req_rs    = r;
    req_data  = d;
    @(negedge clk);
    chk("ready_drop", 32'(req_ready), 0);
    chk("e_after_accept", 32'(e), 1);
    if (!hold_valid) req_valid = 1'b0;
  endtask

  task automatic do_init(input int from);
    for (int i = from; i < 8; i++) begin
      if (i == 7) chk("init_done_early", 32'(init_done), 0);
      check_strobe($sformatf("init%0d", i), 1'b0, init_tbl[i], (i == 5) ? 11 : 3);
    end
    chk("init_done", 32'(init_done), 1);
    chk("ready_after_init", 32'(req_ready), 1);
  endtask

  initial begin
    int rises;
    int acc_cnt;
    logic pe;
    logic [7:0] last;
    bit acc;
    int egap;

    init_tbl = '{8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h08, 8'h01, 8'h06, 8'h0C};
    tbl[0] = '{1'b1, 8'h41, 3};
    tbl[1] = '{1'b0, 8'h01, 11};
    tbl[2] = '{1'b0, 8'h02, 11};
    tbl[3] = '{1'b0, 8'h03, 11};
    tbl[4] = '{1'b0, 8'h80, 3};
    tbl[5] = '{1'b1, 8'h5A, 3};
    tbl[6] = '{1'b0, 8'h04, 3};

    repeat (3) @(negedge clk);
    chk("rst.e", 32'(e), 0);
    chk("rst.rs", 32'(rs), 0);
    chk("rst.data", 32'(data_out), 0);
    chk("rst.ready", 32'(req_ready), 0);
    chk("rst.init_done", 32'(init_done), 0);
    rst_n = 1'b1;
    do_init(0);

    for (int i = 0; i < 7; i++) begin
      send(tbl[i].rs, tbl[i].d, 1'b0);
      check_strobe($sformatf("req%0d", i), tbl[i].rs, tbl[i].d, tbl[i].gap);
    end

    // Request held through strobe and HOLD: only one further acceptance expected.
    send(1'b1, 8'h43, 1'b1);
    req_data = 8'h44;
    rises = 0;
    acc_cnt = 0;
    pe = 1'b1;
    last = 8'h00;
    acc = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (acc) req_valid = 1'b0;
      if (req_valid && req_ready) begin
        acc = 1'b1;
        acc_cnt++;
      end
      @(negedge clk);
      if (e && !pe) begin
        rises++;
        last = data_out;
      end
      pe = e;
    end
    req_valid = 1'b0;
    chk("held.rises", rises, 1);
    chk("held.data", 32'(last), 32'h44);
    chk("held.accepts", acc_cnt, 1);
    chk("held.idle_ready", 32'(req_ready), 1);

    // Reset on second cycle of a data strobe.
    send(1'b1, 8'h55, 1'b0);
    @(negedge clk);
    chk("midrst.e_before", 32'(e), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst.e", 32'(e), 0);
    chk("midrst.data", 32'(data_out), 0);
    chk("midrst.init_done", 32'(init_done), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_init(0);

    // Two lines worth of characters: wrap commands only exist with cursor tracking.
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 16; i++) begin
`ifdef LCD_WRAP_EN
        egap = (i == 15) ? 4 : 3;
`else
        egap = 3;
`endif
        send(1'b1, 8'(8'h30 + i), 1'b0);
        check_strobe($sformatf("line%0d_ch%0d", b, i), 1'b1, 8'(8'h30 + i), egap);
      end
`ifdef LCD_WRAP_EN
      check_strobe($sformatf("wrap%0d", b), 1'b0, (b == 0) ? 8'hC0 : 8'h80, 3);
`endif
      chk($sformatf("line%0d_ready", b), 32'(req_ready), 1);
      chk($sformatf("line%0d_e_low", b), 32'(e), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
